// File: rtl/time_set_if.sv
// time_set_if: set-mode controls, live time in, edited time and load strobe out.
`default_nettype none

interface time_set_if;
  logic       set_en;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_next;
  logic [3:0] cur_hour_t;
  logic [3:0] cur_hour_u;
  logic [3:0] cur_min_t;
  logic [3:0] cur_min_u;
  logic [3:0] cur_sec_t;
  logic [3:0] cur_sec_u;
  logic [3:0] hour_t;
  logic [3:0] hour_u;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic [1:0] field;
  logic       editing;
  logic       load;

  modport master (
    output set_en, btn_inc, btn_dec, btn_next,
    output cur_hour_t, cur_hour_u, cur_min_t, cur_min_u, cur_sec_t, cur_sec_u,
    input  hour_t, hour_u, min_t, min_u, sec_t, sec_u, field, editing, load
  );

  modport slave (
    input  set_en, btn_inc, btn_dec, btn_next,
    input  cur_hour_t, cur_hour_u, cur_min_t, cur_min_u, cur_sec_t, cur_sec_u,
    output hour_t, hour_u, min_t, min_u, sec_t, sec_u, field, editing, load
  );
endinterface

`default_nettype wire

// File: rtl/time_set_ctrl.sv
// ============================================================================
// time_set_ctrl: field-by-field BCD time editor with load strobe on exit.
// Hold-to-repeat built only with TIME_SET_AUTOREPEAT_EN defined.  Rev 1.0
// ============================================================================
`default_nettype none

module time_set_ctrl #(
  parameter int HOUR24        = 1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  time_set_if.slave   bus
);

  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd2;
  localparam logic [3:0] HOUR_RST_T = (HOUR24 != 0) ? 4'd0 : 4'd1;
  localparam logic [3:0] HOUR_RST_U = (HOUR24 != 0) ? 4'd0 : 4'd2;
  localparam logic [7:0] HOUR_LO    = (HOUR24 != 0) ? 8'd0 : 8'd1;
  localparam logic [7:0] HOUR_HI    = (HOUR24 != 0) ? 8'd23 : 8'd12;
  localparam logic [7:0] MS_LO      = 8'd0;
  localparam logic [7:0] MS_HI      = 8'd59;

  logic [3:0] r_hour_t, r_hour_u, r_min_t, r_min_u, r_sec_t, r_sec_u;
  logic [1:0] r_field;
  logic       r_editing;
  logic       r_load;
  logic       r_inc_q, r_dec_q, r_next_q;

  logic       w_edit, w_entry;
  logic       w_inc_press, w_dec_press, w_next_press;
  logic       w_rpt_up, w_rpt_dn;
  logic       w_up, w_dn;
  logic [3:0] w_sel_t, w_sel_u;
  logic [7:0] w_lo, w_hi, w_val, w_new;
  logic       w_valid;
  logic [3:0] w_new_t, w_new_u;

  assign w_edit       = bus.set_en & r_editing;
  assign w_entry      = bus.set_en & ~r_editing;
  assign w_inc_press  = bus.btn_inc & ~r_inc_q;
  assign w_dec_press  = bus.btn_dec & ~r_dec_q;
  assign w_next_press = bus.btn_next & ~r_next_q;

  assign w_up = w_edit & ((w_inc_press & ~w_dec_press) | w_rpt_up);
  assign w_dn = w_edit & ((w_dec_press & ~w_inc_press) | w_rpt_dn);

  // Repeat timing parameters are only meaningful when auto-repeat is built.
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_illegal
  end

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_phase;
  logic             r_rpt_arm;
  logic [RPT_W-1:0] w_rpt_next, w_rpt_thr;
  logic             w_one_held, w_rpt_hit;

  assign w_rpt_next = r_rpt_cnt + RPT_W'(1);
  assign w_rpt_thr  = r_rpt_phase ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
  assign w_one_held = bus.btn_inc ^ bus.btn_dec;
  assign w_rpt_hit  = w_edit & r_rpt_arm & w_one_held & ~w_inc_press & ~w_dec_press
                    & (w_rpt_next == w_rpt_thr);
  assign w_rpt_up   = w_rpt_hit & bus.btn_inc;
  assign w_rpt_dn   = w_rpt_hit & bus.btn_dec;

  // Arm only on a real press so a button held across entry never repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_rpt_arm   <= 1'b0;
    end else if (!w_edit || !w_one_held) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_rpt_arm   <= 1'b0;
    end else if (w_inc_press || w_dec_press) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_rpt_arm   <= 1'b1;
    end else if (r_rpt_arm) begin
      if (w_rpt_next == w_rpt_thr) begin
        r_rpt_cnt   <= '0;
        r_rpt_phase <= 1'b1;
      end else begin
        r_rpt_cnt   <= w_rpt_next;
      end
    end
  end
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
`endif

  always_comb begin
    w_sel_t = r_hour_t;
    w_sel_u = r_hour_u;
    w_lo    = HOUR_LO;
    w_hi    = HOUR_HI;
    case (r_field)
      FIELD_MIN: begin
        w_sel_t = r_min_t;
        w_sel_u = r_min_u;
        w_lo    = MS_LO;
        w_hi    = MS_HI;
      end
      FIELD_SEC: begin
        w_sel_t = r_sec_t;
        w_sel_u = r_sec_u;
        w_lo    = MS_LO;
        w_hi    = MS_HI;
      end
      default: ;
    endcase
    w_val   = {4'd0, w_sel_t} * 8'd10 + {4'd0, w_sel_u};
    w_valid = (w_sel_u <= 4'd9) && (w_val >= w_lo) && (w_val <= w_hi);
    // Out-of-range captures snap to the field minimum on their first step.
    w_new   = w_lo;
    if (w_valid) begin
      if (w_up) w_new = (w_val == w_hi) ? w_lo : w_val + 8'd1;
      else      w_new = (w_val == w_lo) ? w_hi : w_val - 8'd1;
    end
    w_new_t = 4'(w_new / 8'd10);
    w_new_u = 4'(w_new % 8'd10);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hour_t  <= HOUR_RST_T;
      r_hour_u  <= HOUR_RST_U;
      r_min_t   <= 4'd0;
      r_min_u   <= 4'd0;
      r_sec_t   <= 4'd0;
      r_sec_u   <= 4'd0;
      r_field   <= FIELD_HOUR;
      r_editing <= 1'b0;
      r_load    <= 1'b0;
      r_inc_q   <= 1'b0;
      r_dec_q   <= 1'b0;
      r_next_q  <= 1'b0;
    end else begin
      r_inc_q   <= bus.btn_inc;
      r_dec_q   <= bus.btn_dec;
      r_next_q  <= bus.btn_next;
      r_editing <= bus.set_en;
      r_load    <= ~bus.set_en & r_editing;
      if (w_entry) begin
        r_hour_t <= bus.cur_hour_t;
        r_hour_u <= bus.cur_hour_u;
        r_min_t  <= bus.cur_min_t;
        r_min_u  <= bus.cur_min_u;
        r_sec_t  <= bus.cur_sec_t;
        r_sec_u  <= bus.cur_sec_u;
        r_field  <= FIELD_HOUR;
      end else if (w_edit) begin
        if (w_up || w_dn) begin
          case (r_field)
            FIELD_MIN: begin
              r_min_t <= w_new_t;
              r_min_u <= w_new_u;
            end
            FIELD_SEC: begin
              r_sec_t <= w_new_t;
              r_sec_u <= w_new_u;
            end
            default: begin
              r_hour_t <= w_new_t;
              r_hour_u <= w_new_u;
            end
          endcase
        end
        if (w_next_press) begin
          r_field <= (r_field == FIELD_SEC) ? FIELD_HOUR : r_field + 2'd1;
        end
      end
    end
  end

  assign bus.hour_t  = r_hour_t;
  assign bus.hour_u  = r_hour_u;
  assign bus.min_t   = r_min_t;
  assign bus.min_u   = r_min_u;
  assign bus.sec_t   = r_sec_t;
  assign bus.sec_u   = r_sec_u;
  assign bus.field   = r_field;
  assign bus.editing = r_editing;
  assign bus.load    = r_load;

endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed stimulus on a 24h and a 12h instance, timestamped
// expectations checked by a separate scoreboard monitor.
`default_nettype none

module tb_time_set_ctrl;

  localparam int INC = 0;
  localparam int DEC = 1;
  localparam int NXT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  logic [1:0]  set_en, btn_inc, btn_dec, btn_next;
  logic [23:0] cur [2];
  logic [23:0] out_t [2];
  logic [1:0]  out_f [2];
  logic [1:0]  out_ed, out_ld;

  typedef struct {
    int          cyc;
    int          d;
    int          id;
    logic [23:0] t;
    logic [1:0]  f;
    logic        ed;
    logic        ld;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   id_ctr   = 0;

  time_set_if ifa ();
  time_set_if ifb ();

  assign ifa.set_en     = set_en[0];
  assign ifa.btn_inc    = btn_inc[0];
  assign ifa.btn_dec    = btn_dec[0];
  assign ifa.btn_next   = btn_next[0];
  assign ifa.cur_hour_t = cur[0][23:20];
  assign ifa.cur_hour_u = cur[0][19:16];
  assign ifa.cur_min_t  = cur[0][15:12];
  assign ifa.cur_min_u  = cur[0][11:8];
  assign ifa.cur_sec_t  = cur[0][7:4];
  assign ifa.cur_sec_u  = cur[0][3:0];
  assign ifb.set_en     = set_en[1];
  assign ifb.btn_inc    = btn_inc[1];
  assign ifb.btn_dec    = btn_dec[1];
  assign ifb.btn_next   = btn_next[1];
  assign ifb.cur_hour_t = cur[1][23:20];
  assign ifb.cur_hour_u = cur[1][19:16];
  assign ifb.cur_min_t  = cur[1][15:12];
  assign ifb.cur_min_u  = cur[1][11:8];
  assign ifb.cur_sec_t  = cur[1][7:4];
  assign ifb.cur_sec_u  = cur[1][3:0];

  assign out_t[0] = {ifa.hour_t, ifa.hour_u, ifa.min_t, ifa.min_u, ifa.sec_t, ifa.sec_u};
  assign out_t[1] = {ifb.hour_t, ifb.hour_u, ifb.min_t, ifb.min_u, ifb.sec_t, ifb.sec_u};
  assign out_f[0] = ifa.field;
  assign out_f[1] = ifb.field;
  assign out_ed   = {ifb.editing, ifa.editing};
  assign out_ld   = {ifb.load, ifa.load};

  time_set_ctrl #(.HOUR24(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u_dut24 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  time_set_ctrl #(.HOUR24(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u_dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle; any load not expected is an error.
  always @(negedge clk) begin
    logic [1:0] ld_ok;
    exp_t       e;
    ld_ok = 2'b00;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL chk%0d stale dut=%0d actual cyc=%0d required cyc=%0d", e.id, e.d, cyc, e.cyc);
      end else begin
        if (e.ld) ld_ok[e.d] = 1'b1;
        if (out_t[e.d] !== e.t || out_f[e.d] !== e.f || out_ed[e.d] !== e.ed || out_ld[e.d] !== e.ld) begin
          n_fail++;
          $display("FAIL chk%0d dut=%0d cyc=%0d actual t=%h f=%0d ed=%b ld=%b required t=%h f=%0d ed=%b ld=%b",
                   e.id, e.d, cyc, out_t[e.d], out_f[e.d], out_ed[e.d], out_ld[e.d], e.t, e.f, e.ed, e.ld);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (out_ld[d] === 1'b1 && !ld_ok[d]) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_load dut=%0d cyc=%0d actual ld=1 required ld=0", d, cyc);
      end
    end
  end

  task automatic expect_at(int d, logic [23:0] t, logic [1:0] f, logic ed, logic ld, int dt);
    exp_t e;
    e.cyc = cyc + dt; e.d = d; e.id = id_ctr; e.t = t; e.f = f; e.ed = ed; e.ld = ld;
    id_ctr++;
    sb.push_back(e);
  endtask

  task automatic step(int d, logic [23:0] t, logic [1:0] f, logic ed, logic ld);
    expect_at(d, t, f, ed, ld, 1);
    @(negedge clk);
  endtask

  task automatic press(int d, int b, logic [23:0] t, logic [1:0] f);
    if (b == INC) btn_inc[d] = 1'b1;
    if (b == DEC) btn_dec[d] = 1'b1;
    if (b == NXT) btn_next[d] = 1'b1;
    step(d, t, f, 1'b1, 1'b0);
    btn_inc[d] = 1'b0; btn_dec[d] = 1'b0; btn_next[d] = 1'b0;
    step(d, t, f, 1'b1, 1'b0);
  endtask

  task automatic enter(int d, logic [23:0] c);
    cur[d]    = c;
    set_en[d] = 1'b1;
    step(d, c, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic leave(int d, logic [23:0] t, logic [1:0] f);
    set_en[d] = 1'b0;
    step(d, t, f, 1'b0, 1'b1);
    step(d, t, f, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m;
    set_en = '0; btn_inc = '0; btn_dec = '0; btn_next = '0;
    cur[0] = '0; cur[1] = '0;
    @(negedge clk);
    expect_at(0, 24'h000000, 2'd0, 1'b0, 1'b0, 1);
    expect_at(1, 24'h120000, 2'd0, 1'b0, 1'b0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 24h instance: capture and load
    enter(0, 24'h134507);
    leave(0, 24'h134507, 2'd0);

    // Hour wrap both ways, field walk, second wrap without minute carry
    enter(0, 24'h235959);
    press(0, INC, 24'h005959, 2'd0);
    press(0, DEC, 24'h235959, 2'd0);
    press(0, NXT, 24'h235959, 2'd1);
    press(0, NXT, 24'h235959, 2'd2);
    press(0, INC, 24'h235900, 2'd2);
    btn_next[0] = 1'b1; btn_inc[0] = 1'b1;
    step(0, 24'h235901, 2'd0, 1'b1, 1'b0);
    btn_next[0] = 1'b0; btn_inc[0] = 1'b0;
    step(0, 24'h235901, 2'd0, 1'b1, 1'b0);
    btn_inc[0] = 1'b1; btn_dec[0] = 1'b1;
    step(0, 24'h235901, 2'd0, 1'b1, 1'b0);
    btn_inc[0] = 1'b0; btn_dec[0] = 1'b0;
    step(0, 24'h235901, 2'd0, 1'b1, 1'b0);
    leave(0, 24'h235901, 2'd0);

    // Idle: buttons and live time ignored
    cur[0] = 24'h010101; btn_inc[0] = 1'b1;
    step(0, 24'h235901, 2'd0, 1'b0, 1'b0);
    btn_inc[0] = 1'b0;
    step(0, 24'h235901, 2'd0, 1'b0, 1'b0);

    // Next held across entry leaves field at HOUR
    btn_next[0] = 1'b1;
    step(0, 24'h235901, 2'd0, 1'b0, 1'b0);
    enter(0, 24'h102030);
    step(0, 24'h102030, 2'd0, 1'b1, 1'b0);
    btn_next[0] = 1'b0;
    step(0, 24'h102030, 2'd0, 1'b1, 1'b0);
    press(0, INC, 24'h112030, 2'd0);
    leave(0, 24'h112030, 2'd0);

    // Out-of-range capture clamps on first step
    enter(0, 24'h253070);
    press(0, DEC, 24'h003070, 2'd0);
    press(0, DEC, 24'h233070, 2'd0);
    press(0, NXT, 24'h233070, 2'd1);
    press(0, NXT, 24'h233070, 2'd2);
    press(0, INC, 24'h233000, 2'd2);
    leave(0, 24'h233000, 2'd2);

    // Hold inc on minutes = 58
    enter(0, 24'h105800);
    press(0, NXT, 24'h105800, 2'd1);
    btn_inc[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
`ifdef TIME_SET_AUTOREPEAT_EN
      m = (k < 4) ? 8'h59 : (k < 6) ? 8'h00 : (k < 8) ? 8'h01 : 8'h02;
`else
      m = 8'h59;
`endif
      step(0, {8'h10, m, 8'h00}, 2'd1, 1'b1, 1'b0);
    end
    btn_inc[0] = 1'b0;
    step(0, {8'h10, m, 8'h00}, 2'd1, 1'b1, 1'b0);

    // 12h instance
    enter(1, 24'h120000);
    press(1, INC, 24'h010000, 2'd0);
    press(1, DEC, 24'h120000, 2'd0);
    press(1, DEC, 24'h110000, 2'd0);
    leave(1, 24'h110000, 2'd0);
    enter(1, 24'h000000);
    press(1, INC, 24'h010000, 2'd0);
    press(1, DEC, 24'h120000, 2'd0);

    // Asynchronous reset while both instances are editing
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_en = '0; btn_inc = '0; btn_dec = '0; btn_next = '0;
    expect_at(0, 24'h000000, 2'd0, 1'b0, 1'b0, 0);
    expect_at(1, 24'h120000, 2'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_at(1, 24'h120000, 2'd0, 1'b0, 1'b0, 1);
      step(0, 24'h000000, 2'd0, 1'b0, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain actual pending=%0d required pending=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/time_set_ctrl.md
# time_set_ctrl

Parametrised time-setting controller for the digital clock. It captures the running time when set mode is entered and edits it one field at a time (hours, minutes, seconds) with increment/decrement buttons, optional hold-to-repeat and 12/24-hour range rules. On leaving set mode it issues a one-cycle load strobe with the edited BCD time, which the timekeeping counter consumes.

## Interface
- HOUR24, default 1: 1 = hours 00–23; 0 = hours 01–12.
- REPEAT_DELAY, default 50_000_000: cycles a step button is held before auto-repeat starts (≥2).
- REPEAT_PERIOD, default 10_000_000: cycles between repeated steps (≥1).
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- set_en  in  1  level; 1 = set mode active.
- btn_inc, btn_dec, btn_next  in  1 each  synchronised, debounced, active-high levels.
- cur_hour_t, cur_hour_u, cur_min_t, cur_min_u, cur_sec_t, cur_sec_u  in  4 each  live BCD time, captured on entry.
- hour_t, hour_u, min_t, min_u, sec_t, sec_u  out  4 each  edited BCD time, registered.
- field  out  2  selected field: 0 HOUR, 1 MIN, 2 SEC. Value 3 is never output.
- editing  out  1  registered copy of set_en.
- load  out  1  one-cycle strobe; the time outputs are valid in the same cycle.

## Operation
- Reset: field=0, editing=0, load=0, all minute and second digits 0. Hours reset to 0/0 when HOUR24=1 and to 1/2 (12) when HOUR24=0. Repeat counters and edge registers clear.
- Entry: on the edge where set_en=1 and editing=0, copy the cur_* digits into the outputs and set field=HOUR. Buttons are ignored on that edge.
- Press detect: a press is btn sampled 1 at this edge and 0 at the previous edge. Button edges are tracked even when set_en=0, so a button already held at entry produces no press.
- Step: arithmetic is on the whole field, never on a single digit.
  - inc wraps HOUR 23→00 (24h) or 12→01 (12h), and MIN/SEC 59→00.
  - dec wraps 00→23, 01→12, or 00→59.
  - The result is re-encoded as two BCD digits.
- Simultaneous inc and dec presses (or both held in repeat): no step, and the repeat counter restarts.
- btn_next press: field advances HOUR→MIN→SEC→HOUR. A next press in the same cycle as a step applies the step to the old field first.
- Captured values that are out of range (e.g. hour 25, or 00 in 12h mode) are clamped to the field minimum at the first step on that field. They are otherwise held unchanged.
- Exit: on the edge where set_en=0 and editing=1, load=1 for exactly that cycle. Outputs are held until the next entry.
- With set_en=0 all buttons are ignored and outputs are frozen.
- Reset asserted mid-edit: immediate return to reset values. No load is issued.

## Timing
- Step or field change becomes visible on the outputs at the same edge that detects the press (1 cycle after the button first reaches a sampled 1).
- Entry capture: outputs reflect cur_* one edge after set_en rises. editing rises at that same edge.
- load rises one edge after set_en falls and stays high for exactly 1 cycle.
- Auto-repeat: a repeated step is produced every REPEAT_PERIOD cycles after the button has been held REPEAT_DELAY cycles past the press edge. Release at any point stops repeat, and the counter restarts on the next press.

## Configuration
- TIME_SET_AUTOREPEAT_EN defined: the hold-to-repeat logic and counters are built as described above.
- TIME_SET_AUTOREPEAT_EN undefined: one step per press only. REPEAT_DELAY and REPEAT_PERIOD are unused, and no counter logic is synthesised.

## Test plan
- Reset, then set_en=1 with cur=13:45:07 → outputs 13:45:07, field=0. Drop set_en → load=1 for 1 cycle carrying 13:45:07.
- HOUR24=1, hour=23, one inc press → 00. Then one dec press → 23. Press next twice, then inc with sec=59 → sec 00, minutes unchanged.
- HOUR24=0, hour=12, inc → 01. Then dec twice → 11. Captured hour 00 with inc → 01.
- inc and dec rising on the same edge → no value change. btn_next held across entry → field stays HOUR.
- Autorepeat built, REPEAT_DELAY=4, REPEAT_PERIOD=2, hold inc for 10 cycles on MIN=58 → steps at press, +4 and +6 cycles, +8 cycles → 58,59,00,01,02.
- Assert rst_n low mid-edit → all outputs at reset values asynchronously, with no load pulse.
